// File: rtl/logic_op_pipe_if.sv
// Operand/result handshake bundle for logic_op_pipe.
// The block drives the slave side; the environment drives the master side.
interface logic_op_pipe_if #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 16
) ();
    logic             start;
    logic             in_ready;
    logic [WIDTH-1:0] in1;
    logic [WIDTH-1:0] in2;
    logic [2:0]       op_sel;
    logic             acc_mode;
    logic             acc_last;
    logic [WIDTH-1:0] out;
    logic             out_valid;
    logic             out_ready;
    logic             finish;
    logic             busy;
    logic [CNT_W-1:0] done_cnt;

    modport master (
        output start, in1, in2, op_sel, acc_mode, acc_last, out_ready,
        input  in_ready, out, out_valid, finish, busy, done_cnt
    );

    modport slave (
        input  start, in1, in2, op_sel, acc_mode, acc_last, out_ready,
        output in_ready, out, out_valid, finish, busy, done_cnt
    );
endinterface

// File: rtl/logic_op_pipe.sv
// Bitwise-logic pipeline: single-beat ops with one-cycle latency, or multi-beat
// accumulation bursts folding in2 into an accumulator with the opening op.
module logic_op_pipe #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    logic_op_pipe_if.slave bus
);

    typedef enum logic {
        IDLE = 1'b0,
        ACC  = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [2:0]       op_q, op_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic             out_valid_q, out_valid_d;
    logic             finish_q, finish_d;
    logic             busy_q, busy_d;
    logic [CNT_W-1:0] done_cnt_q, done_cnt_d;

    logic             in_ready_c;
    logic             xfer_c;
    logic             consume_c;
    logic             load_res_c;
    logic [WIDTH-1:0] res_c;

    function automatic logic [WIDTH-1:0] op_f(
        input logic [2:0]       op,
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] b
    );
        case (op)
            3'd0:    op_f = a & b;
            3'd1:    op_f = a | b;
            3'd2:    op_f = ~(a ^ b);
            3'd3:    op_f = a ^ b;
            3'd4:    op_f = ~(a & b);
            3'd5:    op_f = ~(a | b);
            3'd6:    op_f = a & ~b;
            default: op_f = a;
        endcase
    endfunction

    // A stalled result blocks new beats so out can never be overwritten unseen.
    assign in_ready_c = !out_valid_q || bus.out_ready;

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        op_d        = op_q;
        out_d       = out_q;
        out_valid_d = out_valid_q;
        done_cnt_d  = done_cnt_q;
        load_res_c  = 1'b0;
        res_c       = '0;
        xfer_c      = bus.start && in_ready_c;
        consume_c   = out_valid_q && bus.out_ready;
        finish_d    = consume_c;

        case (state_q)
            IDLE: begin
                if (xfer_c) begin
                    res_c = op_f(bus.op_sel, bus.in1, bus.in2);
                    if (bus.acc_mode && !bus.acc_last) begin
                        acc_d   = res_c;
                        op_d    = bus.op_sel;
                        state_d = ACC;
                    end else begin
                        load_res_c = 1'b1;
                    end
                end
            end
            ACC: begin
                if (xfer_c) begin
                    res_c = op_f(op_q, acc_q, bus.in2);
                    if (bus.acc_last) begin
                        load_res_c = 1'b1;
                        state_d    = IDLE;
                    end else begin
                        acc_d = res_c;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (load_res_c) begin
            out_d       = res_c;
            out_valid_d = 1'b1;
            if (done_cnt_q != {CNT_W{1'b1}}) begin
                done_cnt_d = done_cnt_q + CNT_W'(1);
            end
        end else if (consume_c) begin
            out_valid_d = 1'b0;
        end

        busy_d = (state_d == ACC);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            op_q        <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            finish_q    <= 1'b0;
            busy_q      <= 1'b0;
            done_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            op_q        <= op_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            finish_q    <= finish_d;
            busy_q      <= busy_d;
            done_cnt_q  <= done_cnt_d;
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out       = out_q;
    assign bus.out_valid = out_valid_q;
    assign bus.finish    = finish_q;
    assign bus.busy      = busy_q;
    assign bus.done_cnt  = done_cnt_q;

endmodule

// File: tb/tb_logic_op_pipe.sv
// Bench for logic_op_pipe: directed table, hand sequences and random traffic
// against a truth-table reference model; a CNT_W=2 twin tracks counter saturation.
module tb_logic_op_pipe;

    localparam int unsigned W  = 8;
    localparam int unsigned CW = 16;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic_op_pipe_if #(.WIDTH(W), .CNT_W(CW)) bus ();
    logic_op_pipe_if #(.WIDTH(W), .CNT_W(2))  sbus ();

    logic_op_pipe #(.WIDTH(W), .CNT_W(CW)) dut  (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
    logic_op_pipe #(.WIDTH(W), .CNT_W(2))  sdut (.clk(clk), .rst_n(rst_n), .bus(sbus.slave));

    assign sbus.start     = bus.start;
    assign sbus.in1       = bus.in1;
    assign sbus.in2       = bus.in2;
    assign sbus.op_sel    = bus.op_sel;
    assign sbus.acc_mode  = bus.acc_mode;
    assign sbus.acc_last  = bus.acc_last;
    assign sbus.out_ready = bus.out_ready;

    int checks = 0;
    int errors = 0;

    // Reference state, kept at transaction level.
    logic [W-1:0] m_out    = '0;
    bit           m_valid  = 0;
    bit           m_finish = 0;
    int           m_cnt    = 0;
    bit           m_burst  = 0;
    logic [W-1:0] m_acc    = '0;
    logic [2:0]   m_op     = '0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Each operation as a 4-entry truth table indexed by {a_bit, b_bit}.
    function automatic logic [W-1:0] ref_f(input logic [2:0] op, input logic [W-1:0] a,
                                           input logic [W-1:0] b);
        logic [31:0] tbl;
        logic [W-1:0] r;
        tbl = 32'hC41769E8;
        for (int i = 0; i < int'(W); i++) begin
            r[i] = tbl[int'(op) * 4 + int'({a[i], b[i]})];
        end
        return r;
    endfunction

    // One clock: check in_ready, advance model, check all outputs after the edge.
    task automatic step();
        bit           rdy, fire, cons, res;
        logic [W-1:0] r;
        #1;
        rdy = !m_valid || bus.out_ready;
        if (rst_n) chk("in_ready", {63'd0, bus.in_ready}, {63'd0, rdy});
        res = 0;
        r   = '0;
        if (!rst_n) begin
            m_out = '0; m_valid = 0; m_finish = 0; m_cnt = 0;
            m_burst = 0; m_acc = '0; m_op = '0;
        end else begin
            fire = bus.start && rdy;
            cons = m_valid && bus.out_ready;
            if (fire) begin
                if (!m_burst) begin
                    r = ref_f(bus.op_sel, bus.in1, bus.in2);
                    if (bus.acc_mode && !bus.acc_last) begin
                        m_burst = 1; m_acc = r; m_op = bus.op_sel;
                    end else res = 1;
                end else begin
                    r = ref_f(m_op, m_acc, bus.in2);
                    if (bus.acc_last) begin
                        res = 1; m_burst = 0;
                    end else m_acc = r;
                end
            end
            m_finish = cons;
            if (res) begin
                m_out = r; m_valid = 1;
                if (m_cnt < 65535) m_cnt++;
            end else if (cons) m_valid = 0;
        end
        @(posedge clk);
        #1;
        chk("out",        64'(bus.out),        64'(m_out));
        chk("out_valid",  64'(bus.out_valid),  64'(m_valid));
        chk("finish",     64'(bus.finish),     64'(m_finish));
        chk("busy",       64'(bus.busy),       64'(m_burst));
        chk("done_cnt",   64'(bus.done_cnt),   64'(m_cnt));
        chk("sat_out",    64'(sbus.out),       64'(m_out));
        chk("sat_valid",  64'(sbus.out_valid), 64'(m_valid));
        chk("sat_finish", 64'(sbus.finish),    64'(m_finish));
        chk("sat_busy",   64'(sbus.busy),      64'(m_burst));
        chk("sat_in_rdy", 64'(sbus.in_ready),  64'(bus.in_ready));
        chk("sat_cnt",    64'(sbus.done_cnt),  64'((m_cnt > 3) ? 3 : m_cnt));
    endtask

    task automatic beat(input bit st, input logic [2:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input bit am, input bit al, input bit ordy);
        bus.start = st; bus.op_sel = op; bus.in1 = a; bus.in2 = b;
        bus.acc_mode = am; bus.acc_last = al; bus.out_ready = ordy;
        step();
    endtask

    typedef struct {
        logic [2:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] exp;
    } vec_t;

    vec_t vecs [10];

    initial begin
        vecs[0] = '{3'd0, 8'hC5, 8'h5A, 8'h40};
        vecs[1] = '{3'd1, 8'hC5, 8'h5A, 8'hDF};
        vecs[2] = '{3'd2, 8'hC5, 8'h5A, 8'h60};
        vecs[3] = '{3'd3, 8'hC5, 8'h5A, 8'h9F};
        vecs[4] = '{3'd4, 8'hC5, 8'h5A, 8'hBF};
        vecs[5] = '{3'd5, 8'hC5, 8'h5A, 8'h20};
        vecs[6] = '{3'd6, 8'hC5, 8'h5A, 8'h85};
        vecs[7] = '{3'd7, 8'hC5, 8'h5A, 8'hC5};
        vecs[8] = '{3'd4, 8'hFF, 8'hFF, 8'h00};
        vecs[9] = '{3'd5, 8'h00, 8'h00, 8'hFF};

        // Reset held two cycles.
        rst_n = 1'b0;
        beat(1, 3'd3, 8'hA5, 8'h0F, 0, 0, 1);
        beat(1, 3'd3, 8'hA5, 8'h0F, 0, 0, 1);
        chk("rst_out",   64'(bus.out), 64'h00);
        chk("rst_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_busy",  64'(bus.busy), 64'd0);
        chk("rst_cnt",   64'(bus.done_cnt), 64'd0);
        chk("rst_rdy",   64'(bus.in_ready), 64'd1);
        rst_n = 1'b1;

        // Single op then its consumption.
        beat(1, 3'd3, 8'hA5, 8'h0F, 0, 0, 1);
        chk("single_out", 64'(bus.out), 64'hAA);
        chk("single_cnt", 64'(bus.done_cnt), 64'd1);
        beat(0, 3'd0, 8'h00, 8'h00, 0, 0, 1);
        chk("single_fin", 64'(bus.finish), 64'd1);

        // Backpressure.
        beat(1, 3'd3, 8'hA5, 8'h0F, 0, 0, 0);
        beat(1, 3'd0, 8'hF0, 8'h3C, 0, 0, 0);
        chk("bp_rdy",  64'(bus.in_ready), 64'd0);
        chk("bp_hold", 64'(bus.out), 64'hAA);
        beat(1, 3'd0, 8'hF0, 8'h3C, 0, 0, 1);
        chk("bp_out", 64'(bus.out), 64'h30);
        chk("bp_fin", 64'(bus.finish), 64'd1);
        beat(0, 3'd0, 8'h00, 8'h00, 0, 0, 1);
        beat(0, 3'd0, 8'h00, 8'h00, 0, 0, 1);
        chk("bp_fin_once", 64'(bus.finish), 64'd0);

        // Accumulation burst with op_sel changed mid-burst.
        beat(1, 3'd1, 8'h01, 8'h02, 1, 0, 1);
        chk("acc_busy1", 64'(bus.busy), 64'd1);
        beat(1, 3'd0, 8'h55, 8'h04, 1, 0, 1);
        chk("acc_busy2", 64'(bus.busy), 64'd1);
        chk("acc_noval", 64'(bus.out_valid), 64'd0);
        beat(1, 3'd0, 8'h00, 8'h80, 0, 1, 1);
        chk("acc_out", 64'(bus.out), 64'h87);
        chk("acc_cnt", 64'(bus.done_cnt), 64'd4);
        chk("acc_idle", 64'(bus.busy), 64'd0);

        // Table of all ops, back-to-back with continuous consumption.
        for (int i = 0; i < 10; i++) begin
            beat(1, vecs[i].op, vecs[i].a, vecs[i].b, 0, 0, 1);
            chk($sformatf("vec%0d", i), 64'(bus.out), 64'(vecs[i].exp));
        end
        chk("sat_cnt3", 64'(sbus.done_cnt), 64'd3);

        // Reset during an open burst.
        beat(1, 3'd2, 8'h12, 8'h34, 1, 0, 1);
        rst_n = 1'b0;
        beat(1, 3'd3, 8'hFF, 8'h00, 0, 0, 1);
        chk("mid_busy",  64'(bus.busy), 64'd0);
        chk("mid_valid", 64'(bus.out_valid), 64'd0);
        chk("mid_cnt",   64'(bus.done_cnt), 64'd0);
        rst_n = 1'b1;
        beat(1, 3'd3, 8'hA5, 8'h0F, 0, 0, 1);
        chk("mid_fresh", 64'(bus.out), 64'hAA);
        chk("mid_cnt1",  64'(bus.done_cnt), 64'd1);

        // Random traffic.
        for (int n = 0; n < 3000; n++) begin
            rst_n = ($urandom_range(0, 199) != 0);
            beat(($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)),
                 W'($urandom), W'($urandom),
                 ($urandom_range(0, 2) == 0), ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 2) != 0));
        end
        rst_n = 1'b1;
        beat(0, 3'd0, 8'h00, 8'h00, 0, 0, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
